// File: rtl/mmio_pkg.sv
// mmio_pkg: bus command codes, LED channel modes and CTRL field layout
package mmio_pkg;
  localparam logic [1:0] MNONE = 2'b00;
  localparam logic [1:0] MREAD = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  typedef enum logic [1:0] {
    LM_STATIC = 2'b00,
    LM_BLINK = 2'b01,
    LM_ROTATE = 2'b10
  } led_mode_t;
  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_W = 2;
  localparam int CTRL_PER_LSB = 8;
  localparam int CTRL_PER_W = 8;
endpackage

// File: rtl/led_channel.sv
// led_channel: one LED channel with value/control registers and blink/rotate animation
module led_channel
  import mmio_pkg::*;
#(
  parameter int LED_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             wr_val,
  input  logic             wr_ctrl,
  input  logic [15:0]      write_data,
  output logic [15:0]      rd_val,
  output logic [15:0]      rd_ctrl,
  output logic [LED_W-1:0] led
);
  logic [LED_W-1:0] val;
  logic [CTRL_MODE_W-1:0] mode;
  logic [CTRL_PER_W-1:0] period;
  logic [7:0] cnt;
  logic phase, step, evt, unused_wd;
  // a CTRL write restarts the animation, so that cycle's tick is not counted
  assign step = tick && period != '0 && !wr_ctrl;
  assign evt = step && cnt == period - 8'd1;
  assign unused_wd = ^write_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      val <= '0;
      mode <= LM_STATIC;
      period <= '0;
      cnt <= '0;
      phase <= 1'b1;
    end else begin
      if (wr_ctrl) begin
        mode <= write_data[CTRL_MODE_LSB +: CTRL_MODE_W];
        period <= write_data[CTRL_PER_LSB +: CTRL_PER_W];
        cnt <= '0;
        phase <= 1'b1;
      end else if (step) begin
        cnt <= evt ? '0 : cnt + 8'd1;
        if (evt && mode == LM_BLINK) phase <= ~phase;
      end
      if (wr_val) val <= write_data[LED_W-1:0];
      else if (evt && mode == LM_ROTATE) val <= (val << 1) | (val >> (LED_W - 1));
    end
  end
  assign rd_val = 16'(val);
  assign rd_ctrl = {period, 6'd0, mode};
  assign led = (mode == LM_BLINK && !phase) ? '0 : val;
endmodule

// File: rtl/mmio_led_bank.sv
// mmio_led_bank: memory-mapped bank of animated LED channels with registered readback
module mmio_led_bank
  import mmio_pkg::*;
#(
  parameter logic [8:0] BASE_ADDR = 9'h100,
  parameter int NUM_CH = 2,
  parameter int LED_W = 8,
  parameter int PRESCALE = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mem_cmd,
  input  logic [8:0]              mem_addr,
  input  logic [15:0]             write_data,
  output logic [15:0]             read_data,
  output logic                    read_hit,
  output logic [NUM_CH*LED_W-1:0] led_out
);
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] pcnt;
  logic tick, hit, wr, rd;
  logic [8:0] off;
  logic [15:0] rdata;
  logic [15:0] vals [NUM_CH];
  logic [15:0] ctrls [NUM_CH];
  assign off = mem_addr - BASE_ADDR;
  assign hit = mem_addr >= BASE_ADDR && {1'b0, mem_addr} < {1'b0, BASE_ADDR} + 10'(2 * NUM_CH);
  assign wr = hit && mem_cmd == MWRITE;
  assign rd = hit && mem_cmd == MREAD;
  assign tick = pcnt == PW'(PRESCALE - 1);
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    led_channel #(.LED_W(LED_W)) u_ch (
      .clk(clk),
      .reset(reset),
      .tick(tick),
      .wr_val(wr && off[8:1] == 8'(k) && !off[0]),
      .wr_ctrl(wr && off[8:1] == 8'(k) && off[0]),
      .write_data(write_data),
      .rd_val(vals[k]),
      .rd_ctrl(ctrls[k]),
      .led(led_out[k*LED_W +: LED_W])
    );
  end
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (off[8:1] == 8'(k)) rdata = off[0] ? ctrls[k] : vals[k];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      read_data <= '0;
      read_hit <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      read_hit <= rd;
      if (rd) read_data <= rdata;
    end
  end
endmodule

// File: tb/tb_mmio_led_bank.sv
// tb_mmio_led_bank: directed bench with read scoreboard for mmio_led_bank
module tb_mmio_led_bank;
  import mmio_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] mem_cmd = MNONE;
  logic [8:0] mem_addr = '0;
  logic [15:0] write_data = '0;
  logic [15:0] read_data;
  logic read_hit;
  logic [15:0] led_out;
  int ec = 0;
  int vecs = 0;
  int errs = 0;
  logic [15:0] exp_q[$];

  mmio_led_bank #(.BASE_ADDR(9'h100), .NUM_CH(2), .LED_W(8), .PRESCALE(4)) dut (
    .clk(clk),
    .reset(reset),
    .mem_cmd(mem_cmd),
    .mem_addr(mem_addr),
    .write_data(write_data),
    .read_data(read_data),
    .read_hit(read_hit),
    .led_out(led_out)
  );

  always #5 clk = ~clk;
  // edge count since reset release; every 4th edge carries a prescaler tick
  always @(posedge clk) ec <= reset ? 0 : ec + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
    mem_cmd = cmd;
    mem_addr = addr;
    write_data = data;
    step(1);
    mem_cmd = MNONE;
  endtask

  task automatic wr(input logic [8:0] addr, input logic [15:0] data);
    bus(MWRITE, addr, data);
  endtask

  task automatic rd(input string tag, input logic [8:0] addr, input logic [15:0] exp);
    logic [15:0] e;
    exp_q.push_back(exp);
    bus(MREAD, addr, 16'h0);
    e = exp_q.pop_front();
    chk({tag, "_hit"}, read_hit, 1);
    chk(tag, read_data, e);
  endtask

  task automatic rd_miss(input string tag, input logic [8:0] addr, input logic [15:0] hold);
    bus(MREAD, addr, 16'h0);
    chk({tag, "_hit"}, read_hit, 0);
    chk(tag, read_data, hold);
  endtask

  task automatic to_tick();
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (ec % 4 == 0) return;
    end
    vecs++;
    errs++;
    $error("FAIL tick_timeout: observed none expected tick within 8 clk");
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    chk("rst_led", led_out, 16'h0000);
    chk("rst_hit", read_hit, 0);
    chk("rst_rdata", read_data, 16'h0000);
    rd("rst_val0", 9'h100, 16'h0000);
    wr(9'h100, 16'h00A5);
    chk("val0_led", led_out, 16'h00A5);
    rd("val0_rd", 9'h100, 16'h00A5);
    wr(9'h101, 16'h0201);
    to_tick();
    chk("blink_on0", led_out[7:0], 8'hA5);
    step(3);
    chk("blink_on1", led_out[7:0], 8'hA5);
    step(1);
    chk("blink_off0", led_out[7:0], 8'h00);
    step(7);
    chk("blink_off1", led_out[7:0], 8'h00);
    step(1);
    chk("blink_on2", led_out[7:0], 8'hA5);
    wr(9'h101, 16'h0000);
    chk("static0", led_out[7:0], 8'hA5);
    wr(9'h102, 16'h0081);
    chk("val1_led", led_out[15:8], 8'h81);
    wr(9'h103, 16'h0102);
    to_tick();
    chk("rot0", led_out[15:8], 8'h03);
    step(4);
    chk("rot1", led_out[15:8], 8'h06);
    step(4);
    chk("rot2", led_out[15:8], 8'h0C);
    rd("rot_rd", 9'h102, 16'h000C);
    rd("ctrl1_rd", 9'h103, 16'h0102);
    wr(9'h104, 16'hFFFF);
    chk("miss_wr_hit", read_hit, 0);
    wr(9'h0FF, 16'hFFFF);
    rd_miss("miss_104", 9'h104, 16'h0102);
    rd_miss("miss_0ff", 9'h0FF, 16'h0102);
    rd("miss_val0", 9'h100, 16'h00A5);
    rd("miss_ctrl0", 9'h101, 16'h0000);
    wr(9'h101, 16'hFCFD);
    rd("ctrl_rsvd", 9'h101, 16'hFC01);
    wr(9'h100, 16'h12A5);
    rd("val_rsvd", 9'h100, 16'h00A5);
    to_tick();
    step(3);
    wr(9'h102, 16'h0055);
    chk("coinc_keep", led_out[15:8], 8'h55);
    to_tick();
    chk("coinc_next", led_out[15:8], 8'hAA);
    wr(9'h103, 16'h0002);
    chk("freeze0", led_out[15:8], 8'hAA);
    for (int i = 0; i < 40; i++) begin
      step(1);
      chk("freeze", led_out[15:8], 8'hAA);
    end
    wr(9'h101, 16'h0101);
    chk("rb_on", led_out[7:0], 8'hA5);
    to_tick();
    chk("rb_off0", led_out[7:0], 8'h00);
    step(1);
    chk("rb_off1", led_out[7:0], 8'h00);
    reset = 1'b1;
    step(1);
    chk("mid_rst_led", led_out, 16'h0000);
    chk("mid_rst_hit", read_hit, 0);
    chk("mid_rst_rdata", read_data, 16'h0000);
    reset = 1'b0;
    rd("mid_rst_val0", 9'h100, 16'h0000);
    rd("mid_rst_ctrl0", 9'h101, 16'h0000);
    rd("mid_rst_val1", 9'h102, 16'h0000);
    rd("mid_rst_ctrl1", 9'h103, 16'h0000);
    wr(9'h100, 16'h00A5);
    chk("post_rst_val", led_out, 16'h00A5);
    step(8);
    chk("post_rst_static", led_out, 16'h00A5);
    wr(9'h101, 16'h0101);
    chk("resume_on", led_out[7:0], 8'hA5);
    to_tick();
    chk("resume_off", led_out[7:0], 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
